// File: rtl/rule_scheduler_if.sv
// Stimulus/status bundle between the rule scheduler and its controller/system.
// Master drives the run controls and guard vector; slave (the scheduler) answers with the pick and status.
interface rule_scheduler_if #(
  parameter int NUM_RULES = 32,
  parameter int IDX_W     = 5,
  parameter int STEP_W    = 16
);
  logic                 io_start;
  logic                 io_stop;
  logic [1:0]           io_mode;
  logic [15:0]          io_seed;
  logic [STEP_W-1:0]    io_max_steps;
  logic [NUM_RULES-1:0] io_guard;
  logic [IDX_W-1:0]     io_en_a;
  logic                 io_fire;
  logic [STEP_W-1:0]    io_steps;
  logic                 io_busy;
  logic                 io_done;
  logic                 io_deadlock;

  modport master (
    output io_start, io_stop, io_mode, io_seed, io_max_steps, io_guard,
    input  io_en_a, io_fire, io_steps, io_busy, io_done, io_deadlock
  );

  modport slave (
    input  io_start, io_stop, io_mode, io_seed, io_max_steps, io_guard,
    output io_en_a, io_fire, io_steps, io_busy, io_done, io_deadlock
  );
endinterface

// File: rtl/rule_scheduler.sv
// Picks one enabled rule per cycle (round-robin, LFSR-random or lowest-index) and counts fired steps.
// Handshake: io_fire high means io_en_a is valid and the rule fires at the coming rising edge; no back-pressure.
module rule_scheduler #(
  parameter int NUM_RULES = 32,
  parameter int IDX_W     = 5,
  parameter int STEP_W    = 16
) (
  input  logic        clock,
  input  logic        reset,
  rule_scheduler_if.slave bus,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    DEADLOCK = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [15:0]       lfsr_q;
  logic [STEP_W-1:0] steps_q;

  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  chosen;
  logic [IDX_W-1:0]  ptr_d;
  logic [15:0]       lfsr_d;
  logic [STEP_W-1:0] steps_d;
  logic              any_guard;
  logic              fire;
  logic              last_step;

  assign any_guard = |bus.io_guard;
  assign fire      = (state_q == RUN) && !bus.io_stop && !reset && any_guard;

  // Scan start point depends on the live mode so mid-run mode changes act immediately.
  always_comb begin
    int t;
    t         = 0;
    start_idx = '0;
    unique case (bus.io_mode)
      2'd1: start_idx = (int'(lfsr_q[IDX_W-1:0]) >= NUM_RULES) ? '0 : lfsr_q[IDX_W-1:0];
      2'd2: start_idx = '0;
      default: start_idx = ptr_q;
    endcase
    chosen = '0;
    // Walk downward in distance so the nearest set guard at or after start_idx wins.
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      t = int'(start_idx) + k;
      if (t >= NUM_RULES) t = t - NUM_RULES;
      if (bus.io_guard[t]) chosen = IDX_W'(t);
    end
  end

  always_comb begin
    ptr_d     = ((int'(chosen) + 1) >= NUM_RULES) ? '0 : chosen + IDX_W'(1);
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    steps_d   = (steps_q == '1) ? steps_q : steps_q + STEP_W'(1);
    last_step = (bus.io_max_steps != '0) && (steps_q == bus.io_max_steps - STEP_W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lfsr_q  <= LFSR_RESET;
      steps_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          lfsr_q <= lfsr_d;
          if (bus.io_stop) begin
            state_q <= IDLE;
          end else if (!any_guard) begin
            state_q <= DEADLOCK;
          end else begin
            steps_q <= steps_d;
            if (bus.io_mode != 2'd1 && bus.io_mode != 2'd2) ptr_q <= ptr_d;
            if (last_step) state_q <= DONE;
          end
        end
        default: begin
          if (bus.io_start) begin
            state_q <= RUN;
            ptr_q   <= '0;
            steps_q <= '0;
            lfsr_q  <= (bus.io_seed == 16'h0000) ? LFSR_RESET : bus.io_seed;
          end
        end
      endcase
    end
  end

  assign bus.io_fire     = fire;
  assign bus.io_en_a     = fire ? chosen : '0;
  assign bus.io_steps    = steps_q;
  assign bus.io_busy     = (state_q == RUN);
  assign bus.io_done     = (state_q == DONE);
  assign bus.io_deadlock = (state_q == DEADLOCK);
  assign dbg_state_o     = state_q;

endmodule
